spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 150 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-byte SPI master, mode 0 (clock idles low, data
// sampled on the rising edge, changed on the falling edge), MSB first.
//
// Ports
//   clk_i       system clock; all state changes on its rising edge
//   reset_i     synchronous active-low reset
//   start_i     transfer request, sampled every cycle while idle
//   dev_i       target device 0..2 (3 is rejected with err_o)
//   tx_data_i   byte to send, latched when the request is accepted
//   busy_o      high for the whole transfer
//   done_o      one-cycle pulse when the received byte is presented
//   err_o       one-cycle pulse after a request with dev_i = 3
//   rx_data_o   last received byte, held until the next completion
//   spi_clk_o   SPI clock
//   mosi_o      serial data to the slave
//   miso_i      serial data from the slave
//   spi_addr_o  device select code: 0 = none, device n -> n+1
//
// Timing: SETUP, then eight SHIFT_LO/SHIFT_HI pairs, then HOLD.  Each phase
// lasts CLK_DIV cycles, so a transfer is busy for 18*CLK_DIV cycles.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] dev_i,
  input  logic [7:0] tx_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rx_data_o,
  output logic       spi_clk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic [2:0] spi_addr_o
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] tx_sr_q;
  logic [7:0] rx_sr_q;
  logic [7:0] rx_data_q;
  logic [1:0] dev_q;
  logic       done_q;
  logic       err_q;
  logic       div_last;
  logic       accept;
  logic       req_err;

  // Next state and the outputs that follow directly from the state.
  always_comb begin
    div_last   = (div_q == DIV_LAST);
    accept     = 1'b0;
    req_err    = 1'b0;
    state_d    = state_q;
    busy_o     = 1'b1;
    spi_clk_o  = 1'b0;
    mosi_o     = tx_sr_q[7];
    spi_addr_o = {1'b0, dev_q} + 3'd1;
    case (state_q)
      IDLE: begin
        busy_o     = 1'b0;
        mosi_o     = 1'b0;
        spi_addr_o = '0;
        if (start_i) begin
          if (dev_i == 2'd3) begin
            req_err = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (div_last) state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_last) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        spi_clk_o = 1'b1;
        if (div_last) state_d = (bit_q == 3'd0) ? HOLD : SHIFT_LO;
      end
      HOLD: begin
        if (div_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath: the end of a SHIFT_LO phase is the edge that raises spi_clk_o
  // (sample miso); the end of a SHIFT_HI phase lowers it (advance mosi).
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      div_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      dev_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state_q == HOLD) && div_last;
      err_q  <= req_err;

      if (state_d != state_q)  div_q <= '0;
      else if (state_q != IDLE) div_q <= div_q + 8'd1;

      if (accept) begin
        tx_sr_q <= tx_data_i;
        dev_q   <= dev_i;
        bit_q   <= 3'd7;
      end

      if ((state_q == SHIFT_LO) && div_last)
        rx_sr_q <= {rx_sr_q[6:0], miso_i};

      if ((state_q == SHIFT_HI) && div_last) begin
        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
        bit_q   <= bit_q - 3'd1;
      end

      if ((state_q == HOLD) && div_last)
        rx_data_q <= rx_sr_q;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: a CLK_DIV=4 instance for the table,
// random and corner sequences, and a CLK_DIV=1 instance for back-to-back
// transfers.
module tb_spi_master_ctrl;

  localparam int D4   = 4;
  localparam int XFER = 18 * D4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       start4, miso_drv4, loop4, miso4;
  logic [1:0] dev4;
  logic [7:0] tx4;
  logic       busy4, done4, err4, sclk4, mosi4;
  logic [7:0] rx4;
  logic [2:0] addr4;
  assign miso4 = loop4 ? mosi4 : miso_drv4;

  logic       start1, miso1;
  logic [1:0] dev1;
  logic [7:0] tx1;
  logic       busy1, done1, err1, sclk1, mosi1;
  logic [7:0] rx1;
  logic [2:0] addr1;
  assign miso1 = mosi1;

  spi_master_ctrl #(.CLK_DIV(4)) u_dut4 (
    .clk_i(clk), .reset_i(reset_n), .start_i(start4), .dev_i(dev4),
    .tx_data_i(tx4), .busy_o(busy4), .done_o(done4), .err_o(err4),
    .rx_data_o(rx4), .spi_clk_o(sclk4), .mosi_o(mosi4), .miso_i(miso4),
    .spi_addr_o(addr4)
  );

  spi_master_ctrl #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_n), .start_i(start1), .dev_i(dev1),
    .tx_data_i(tx1), .busy_o(busy1), .done_o(done1), .err_o(err1),
    .rx_data_o(rx1), .spi_clk_o(sclk1), .mosi_o(mosi1), .miso_i(miso1),
    .spi_addr_o(addr1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [1:0] dev;
    logic [7:0] mpat;
    bit         loop;
    logic [7:0] exp_rx;
    logic [2:0] exp_addr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] last_rx;

  // The slave's byte as seen on miso, MSB first: loopback returns what was sent.
  function automatic logic [7:0] ref_rx(input logic [7:0] tx, input logic [7:0] mpat, input bit loop);
    return loop ? tx : mpat;
  endfunction

  // One transfer on the CLK_DIV=4 instance, starting at #1 after a posedge in
  // IDLE. Between ign_from and ign_to a competing request is presented.
  task automatic xfer4(input vec_t v, input int ign_from, input int ign_to, input string tag);
    int         rises, first_rise;
    bit         prev, bad_busy, bad_mosi, bad_setup;
    logic [7:0] mosi_seen;
    rises = 0; first_rise = 0; prev = 1'b0;
    bad_busy = 1'b0; bad_mosi = 1'b0; bad_setup = 1'b0; mosi_seen = '0;
    loop4 = v.loop; miso_drv4 = v.mpat[7];
    start4 = 1'b1; dev4 = v.dev; tx4 = v.tx;
    for (int k = 1; k <= XFER; k++) begin
      @(posedge clk); #1;
      if (k >= ign_from && k <= ign_to) begin
        start4 = 1'b1; tx4 = 8'h3C; dev4 = 2'd0;
      end else begin
        start4 = 1'b0;
      end
      if (busy4 !== 1'b1 || addr4 !== v.exp_addr || done4 !== 1'b0 ||
          err4 !== 1'b0 || rx4 !== last_rx) bad_busy = 1'b1;
      if (k <= D4 && (sclk4 !== 1'b0 || mosi4 !== v.tx[7])) bad_setup = 1'b1;
      if (sclk4 && !prev) begin
        if (rises == 0) first_rise = k;
        if (rises < 8) mosi_seen[7-rises] = mosi4;
        rises++;
        if (!v.loop && rises < 8) miso_drv4 = v.mpat[7-rises];
      end
      if (sclk4 && rises >= 1 && rises <= 8 && mosi4 !== v.tx[8-rises]) bad_mosi = 1'b1;
      prev = sclk4;
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    check({tag, " done"},      done4,     1'b1);
    check({tag, " busy_end"},  busy4,     1'b0);
    check({tag, " addr_end"},  addr4,     3'b000);
    check({tag, " mosi_end"},  mosi4,     1'b0);
    check({tag, " rx_data"},   rx4,       v.exp_rx);
    check({tag, " rises"},     rises,     8);
    check({tag, " first_rise"}, first_rise, 2 * D4 + 1);
    check({tag, " mosi_bits"}, mosi_seen, v.tx);
    check({tag, " busy_phase"}, bad_busy, 1'b0);
    check({tag, " setup"},     bad_setup, 1'b0);
    check({tag, " mosi_high"}, bad_mosi,  1'b0);
    last_rx = v.exp_rx;
    @(posedge clk); #1;
    check({tag, " done_pulse"}, done4, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_k[$];
    int   rises1;
    bit   prev1;
    bit   bad_idle;
    vec_t v;

    reset_n = 1'b0;
    start4 = 1'b0; dev4 = '0; tx4 = '0; miso_drv4 = 1'b0; loop4 = 1'b0;
    start1 = 1'b0; dev1 = '0; tx1 = '0;
    last_rx = 8'h00;

    vecs.push_back('{tx: 8'hA5, dev: 2'd1, mpat: 8'h00, loop: 1'b1, exp_rx: 8'hA5, exp_addr: 3'b010});
    vecs.push_back('{tx: 8'h00, dev: 2'd0, mpat: 8'hFF, loop: 1'b0, exp_rx: 8'hFF, exp_addr: 3'b001});
    vecs.push_back('{tx: 8'h3C, dev: 2'd2, mpat: 8'hC3, loop: 1'b0, exp_rx: 8'hC3, exp_addr: 3'b011});
    vecs.push_back('{tx: 8'h81, dev: 2'd1, mpat: 8'h7E, loop: 1'b0, exp_rx: 8'h7E, exp_addr: 3'b010});
    for (int i = 0; i < 12; i++) begin
      v.tx       = 8'($urandom);
      v.dev      = 2'($urandom_range(0, 2));
      v.mpat     = 8'($urandom);
      v.loop     = 1'($urandom_range(0, 1));
      v.exp_rx   = ref_rx(v.tx, v.mpat, v.loop);
      v.exp_addr = 3'(v.dev) + 3'd1;
      vecs.push_back(v);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",  busy4, 1'b0);
    check("rst done",  done4, 1'b0);
    check("rst err",   err4,  1'b0);
    check("rst sclk",  sclk4, 1'b0);
    check("rst mosi",  mosi4, 1'b0);
    check("rst addr",  addr4, 3'b000);
    check("rst rx",    rx4,   8'h00);
    check("rst1 busy", busy1, 1'b0);
    check("rst1 rx",   rx1,   8'h00);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) xfer4(vecs[i], 0, -1, $sformatf("vec%0d", i));

    // Invalid device: one-cycle err, nothing else moves
    start4 = 1'b1; dev4 = 2'd3; tx4 = 8'h77;
    @(posedge clk); #1;
    start4 = 1'b0; dev4 = 2'd0;
    check("err pulse", err4,  1'b1);
    check("err busy",  busy4, 1'b0);
    check("err addr",  addr4, 3'b000);
    check("err sclk",  sclk4, 1'b0);
    check("err done",  done4, 1'b0);
    check("err rx",    rx4,   last_rx);
    @(posedge clk); #1;
    check("err single", err4,  1'b0);
    check("err idle",   busy4, 1'b0);

    // Request during a transfer is ignored
    xfer4('{tx: 8'hC3, dev: 2'd1, mpat: 8'h00, loop: 1'b1, exp_rx: 8'hC3, exp_addr: 3'b010},
          10, 20, "ignore");
    bad_idle = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (busy4 !== 1'b0 || done4 !== 1'b0) bad_idle = 1'b1;
    end
    check("ignore single_done", bad_idle, 1'b0);

    // Reset in the middle of a transfer
    loop4 = 1'b1; start4 = 1'b1; dev4 = 2'd2; tx4 = 8'hFF;
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort busy", busy4, 1'b0);
    check("abort sclk", sclk4, 1'b0);
    check("abort addr", addr4, 3'b000);
    check("abort done", done4, 1'b0);
    check("abort rx",   rx4,   8'h00);
    last_rx = 8'h00;
    bad_idle = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done4 !== 1'b0 || busy4 !== 1'b0) bad_idle = 1'b1;
    end
    check("abort no_done", bad_idle, 1'b0);
    xfer4('{tx: 8'h5A, dev: 2'd0, mpat: 8'h00, loop: 1'b1, exp_rx: 8'h5A, exp_addr: 3'b001},
          0, -1, "post_reset");

    // CLK_DIV=1, start held: back-to-back transfers 19 cycles apart
    start1 = 1'b1; dev1 = 2'd2; tx1 = 8'h96;
    rises1 = 0; prev1 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 58) start1 = 1'b0;
      if (k <= 19 && sclk1 && !prev1) rises1++;
      prev1 = sclk1;
      if (done1) begin
        done_k.push_back(k);
        check($sformatf("div1 rx@%0d", k), rx1, 8'h96);
      end
      if (k == 20) check("div1 no_gap busy", busy1, 1'b1);
      if (k == 20) check("div1 addr", addr1, 3'b011);
    end
    check("div1 rises", rises1, 8);
    check("div1 done_count", done_k.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < done_k.size()) check($sformatf("div1 done%0d", i), done_k[i], 19 * (i + 1));
    check("div1 idle", busy1, 1'b0);
    check("div1 err", err1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
